// File: rtl/mac_filter.sv
// Ethernet MAC address filter on an MSB-first RMII dibit stream: parses the
// 14-byte header, forwards payload dibits only for frames to MY_MAC or broadcast.
//
// state   | meaning
// IDLE    | waiting for axiiv to rise
// DEST    | shifting in destination MAC (dibits 1..24)
// SRC     | shifting in source MAC (dibits 25..48)
// TYPE    | shifting in ethertype (dibits 49..56)
// PAYLOAD | accepted frame, payload dibits forwarded with 1-cycle latency
// DROP    | rejected frame, remaining dibits consumed silently
module mac_filter #(
  parameter logic [47:0] MY_MAC     = 48'h69_69_5A_06_54_91,
  parameter int          HDR_DIBITS = 56
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        axiiv,
  input  logic [1:0]  axiid,
  output logic        axiov,
  output logic [1:0]  axiod,
  output logic        hdr_valid,
  output logic [47:0] src_mac,
  output logic [15:0] ethertype,
  output logic        frame_pass,
  output logic        frame_drop
);

  typedef enum logic [2:0] {
    IDLE,
    DEST,
    SRC,
    TYPE,
    PAYLOAD,
    DROP
  } state_t;

  localparam logic [5:0] DEST_LAST = 6'd23;
  localparam logic [5:0] SRC_LAST  = 6'd47;
  localparam logic [5:0] HDR_LAST  = 6'(HDR_DIBITS - 1);
  localparam logic [5:0] HDR_FULL  = 6'(HDR_DIBITS);

  state_t      state;
  logic [5:0]  count;
  logic [45:0] sh;
  logic [47:0] sh_next;
  logic [47:0] src_pend;
  logic        keep;

  // the incoming dibit completes the 48-bit window on the same edge it is used
  assign sh_next = {sh, axiid};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      count      <= 6'd0;
      sh         <= '0;
      src_pend   <= '0;
      keep       <= 1'b0;
      axiov      <= 1'b0;
      axiod      <= 2'b00;
      hdr_valid  <= 1'b0;
      src_mac    <= '0;
      ethertype  <= '0;
      frame_pass <= 1'b0;
      frame_drop <= 1'b0;
    end else begin
      frame_pass <= 1'b0;
      frame_drop <= 1'b0;
      axiov      <= 1'b0;
      axiod      <= 2'b00;
      if (!axiiv) begin
        if (state != IDLE) begin
          frame_pass <= (state == PAYLOAD);
          frame_drop <= (state != PAYLOAD);
          state      <= IDLE;
          count      <= 6'd0;
        end
      end else begin
        sh <= sh_next[45:0];
        if (count != HDR_FULL) count <= count + 6'd1;
        case (state)
          IDLE: begin
            state     <= DEST;
            count     <= 6'd1;
            hdr_valid <= 1'b0;
          end
          DEST: begin
            if (count == DEST_LAST) begin
              keep  <= (sh_next == MY_MAC) || (sh_next == 48'hFFFF_FFFF_FFFF);
              state <= SRC;
            end
          end
          SRC: begin
            // held aside so a rejected frame never disturbs the published src_mac
            if (count == SRC_LAST) begin
              src_pend <= sh_next;
              state    <= TYPE;
            end
          end
          TYPE: begin
            if (count == HDR_LAST) begin
              hdr_valid <= keep;
              if (keep) begin
                src_mac   <= src_pend;
                ethertype <= sh_next[15:0];
                state     <= PAYLOAD;
              end else begin
                state <= DROP;
              end
            end
          end
          PAYLOAD: begin
            axiov <= 1'b1;
            axiod <= axiid;
          end
          DROP: begin
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mac_filter.sv
// Directed bench for mac_filter: builds dibit frames, checks per-cycle output,
// payload counts, header capture and pass/drop pulses.
module tb_mac_filter;

  localparam logic [47:0] MY_MAC = 48'h69_69_5A_06_54_91;
  localparam logic [47:0] BCAST  = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] NEAR   = 48'h6969_5A06_5490;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        axiiv = 1'b0;
  logic [1:0]  axiid = 2'b00;
  logic        axiov;
  logic [1:0]  axiod;
  logic        hdr_valid;
  logic [47:0] src_mac;
  logic [15:0] ethertype;
  logic        frame_pass;
  logic        frame_drop;

  mac_filter #(.MY_MAC(MY_MAC), .HDR_DIBITS(56)) dut (
    .clk        (clk),
    .rst        (rst),
    .axiiv      (axiiv),
    .axiid      (axiid),
    .axiov      (axiov),
    .axiod      (axiod),
    .hdr_valid  (hdr_valid),
    .src_mac    (src_mac),
    .ethertype  (ethertype),
    .frame_pass (frame_pass),
    .frame_drop (frame_drop)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // monitor: collects forwarded dibits and end-of-frame pulses
  logic [1:0] rx_q[$];
  int         pass_cnt = 0;
  int         drop_cnt = 0;
  int         both_cnt = 0;
  logic [7:0] seq = 8'h00;

  always @(negedge clk) begin
    if (axiov) rx_q.push_back(axiod);
    if (frame_pass) begin
      pass_cnt++;
      seq = {seq[5:0], 2'b01};
    end
    if (frame_drop) begin
      drop_cnt++;
      seq = {seq[5:0], 2'b10};
    end
    if (frame_pass && frame_drop) both_cnt++;
  end

  task automatic clear_stats();
    rx_q.delete();
    pass_cnt = 0;
    drop_cnt = 0;
    seq      = 8'h00;
  endtask

  // frame construction
  logic [1:0] frm[$];

  task automatic push_byte(input logic [7:0] b);
    for (int j = 3; j >= 0; j--) frm.push_back(b[2*j +: 2]);
  endtask

  task automatic build(input logic [47:0] dest, input logic [47:0] src,
                       input logic [15:0] typ, input int npay);
    frm.delete();
    for (int i = 5; i >= 0; i--) push_byte(dest[8*i +: 8]);
    for (int i = 5; i >= 0; i--) push_byte(src[8*i +: 8]);
    push_byte(typ[15:8]);
    push_byte(typ[7:0]);
    for (int k = 0; k < npay; k++) push_byte(8'h3C + 8'(k * 29));
  endtask

  // per-cycle expectation for the output produced by the previous dibit
  logic       pv = 1'b0;
  logic [1:0] pd = 2'b00;

  task automatic check_prev();
    check_val("axiov_cyc", 48'(axiov), 48'(pv));
    if (pv) check_val("axiod_cyc", 48'(axiod), 48'(pd));
  endtask

  task automatic drive_dibit(input logic [1:0] d, input bit v);
    @(negedge clk);
    check_prev();
    axiiv = 1'b1;
    axiid = d;
    pv    = v;
    pd    = d;
  endtask

  task automatic end_frame();
    @(negedge clk);
    check_prev();
    axiiv = 1'b0;
    axiid = 2'b00;
    pv    = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      check_prev();
    end
  endtask

  task automatic send(input bit accept);
    foreach (frm[i]) drive_dibit(frm[i], accept && (i >= 56));
    end_frame();
  endtask

  initial begin
    #1;
    check_val("rst_axiov", 48'(axiov), 48'd0);
    check_val("rst_hdr_valid", 48'(hdr_valid), 48'd0);
    check_val("rst_src_mac", src_mac, 48'd0);
    check_val("rst_ethertype", 48'(ethertype), 48'd0);
    check_val("rst_pulses", 48'({frame_pass, frame_drop}), 48'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(2);

    // unicast
    clear_stats();
    build(MY_MAC, 48'h0011_2233_4455, 16'h0800, 8);
    send(1'b1);
    idle(3);
    check_val("uni_rx_len", 48'(rx_q.size()), 48'd32);
    check_val("uni_pass", 48'(pass_cnt), 48'd1);
    check_val("uni_drop", 48'(drop_cnt), 48'd0);
    check_val("uni_src", src_mac, 48'h0011_2233_4455);
    check_val("uni_type", 48'(ethertype), 48'h0800);
    check_val("uni_hdr_valid", 48'(hdr_valid), 48'd1);

    // mismatch in the last address bit only
    clear_stats();
    build(NEAR, 48'hDEAD_BEEF_0001, 16'h0806, 20);
    send(1'b0);
    idle(3);
    check_val("mis_rx_len", 48'(rx_q.size()), 48'd0);
    check_val("mis_drop", 48'(drop_cnt), 48'd1);
    check_val("mis_pass", 48'(pass_cnt), 48'd0);
    check_val("mis_src_kept", src_mac, 48'h0011_2233_4455);
    check_val("mis_type_kept", 48'(ethertype), 48'h0800);
    check_val("mis_hdr_valid", 48'(hdr_valid), 48'd0);

    // broadcast
    clear_stats();
    build(BCAST, 48'hA1B2_C3D4_E5F6, 16'h86DD, 4);
    send(1'b1);
    idle(3);
    check_val("bc_rx_len", 48'(rx_q.size()), 48'd16);
    check_val("bc_pass", 48'(pass_cnt), 48'd1);
    check_val("bc_src", src_mac, 48'hA1B2_C3D4_E5F6);
    check_val("bc_type", 48'(ethertype), 48'h86DD);
    check_val("bc_hdr_valid", 48'(hdr_valid), 48'd1);

    // runt: matching header cut off inside the source address
    clear_stats();
    build(MY_MAC, 48'h1234_5678_9ABC, 16'h0800, 8);
    while (frm.size() > 30) void'(frm.pop_back());
    send(1'b0);
    idle(3);
    check_val("runt_drop", 48'(drop_cnt), 48'd1);
    check_val("runt_pass", 48'(pass_cnt), 48'd0);
    check_val("runt_rx_len", 48'(rx_q.size()), 48'd0);
    check_val("runt_hdr_valid", 48'(hdr_valid), 48'd0);
    check_val("runt_src_kept", src_mac, 48'hA1B2_C3D4_E5F6);

    // header only, frame ends exactly at dibit 56
    clear_stats();
    build(MY_MAC, 48'h0A0B_0C0D_0E0F, 16'h88B5, 0);
    send(1'b1);
    idle(3);
    check_val("hdr_only_pass", 48'(pass_cnt), 48'd1);
    check_val("hdr_only_drop", 48'(drop_cnt), 48'd0);
    check_val("hdr_only_rx_len", 48'(rx_q.size()), 48'd0);
    check_val("hdr_only_type", 48'(ethertype), 48'h88B5);

    // back-to-back with single-cycle gaps
    clear_stats();
    build(MY_MAC, 48'h0000_0000_0001, 16'h0800, 2);
    send(1'b1);
    build(NEAR, 48'h0000_0000_0002, 16'h0801, 3);
    send(1'b0);
    build(BCAST, 48'h0000_0000_0003, 16'h0802, 1);
    send(1'b1);
    idle(3);
    check_val("b2b_order", 48'(seq), 48'h19);
    check_val("b2b_rx_len", 48'(rx_q.size()), 48'd12);
    check_val("b2b_src", src_mac, 48'h0000_0000_0003);
    check_val("b2b_type", 48'(ethertype), 48'h0802);

    // reset while forwarding payload dibit 10
    clear_stats();
    build(MY_MAC, 48'h5555_6666_7777, 16'h0800, 8);
    for (int i = 0; i < 66; i++) drive_dibit(frm[i], i >= 56);
    @(negedge clk);
    check_prev();
    rst   = 1'b0;
    axiiv = 1'b0;
    axiid = 2'b00;
    pv    = 1'b0;
    #1;
    check_val("mrst_axiov", 48'(axiov), 48'd0);
    check_val("mrst_axiod", 48'(axiod), 48'd0);
    check_val("mrst_hdr_valid", 48'(hdr_valid), 48'd0);
    check_val("mrst_src", src_mac, 48'd0);
    check_val("mrst_type", 48'(ethertype), 48'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle(3);
    check_val("mrst_no_pass", 48'(pass_cnt), 48'd0);
    check_val("mrst_no_drop", 48'(drop_cnt), 48'd0);

    clear_stats();
    build(MY_MAC, 48'h0011_2233_4455, 16'h0800, 8);
    send(1'b1);
    idle(3);
    check_val("post_rst_rx_len", 48'(rx_q.size()), 48'd32);
    check_val("post_rst_pass", 48'(pass_cnt), 48'd1);
    check_val("post_rst_src", src_mac, 48'h0011_2233_4455);
    check_val("post_rst_hdr_valid", 48'(hdr_valid), 48'd1);

    check_val("pulse_overlap", 48'(both_cnt), 48'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
